// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target with clock stretching.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_STRETCH,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  // Address byte is {addr[6:0], r_w}; only writes to our address are accepted.
  function automatic logic is_write_to(input logic [I2C_BYTE_W-1:0] addr_byte,
                                       input logic [I2C_ADDR_W-1:0] addr);
    return (addr_byte[I2C_BYTE_W-1:1] == addr) && !addr_byte[0];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus rise/fall detection for one open-drain bus line.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Flops reset high so an idle bus produces no edges on reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_target_stretch.sv
// Write-only I2C target: ACKs its address, holds SCL low after each data byte
// until the consumer takes it, and NACKs the byte if that takes too long.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | bus free or not yet addressed, waiting for START
// ST_ADDR     | shifting in the address byte
// ST_ADDR_ACK | driving ACK for our address until SCL falls
// ST_DATA     | shifting in a data byte
// ST_STRETCH  | byte presented on rx_data, SCL held low awaiting handshake
// ST_DATA_ACK | driving ACK for the accepted byte until SCL falls
// ST_IGNORE   | not addressed, NACKed, or timed out; waiting for START/STOP
module i2c_target_stretch
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TGT_ADDR    = 7'h42,
  parameter logic [15:0]           STRETCH_MAX = 16'd12000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  scl_oe,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  timeout_err
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (scl_in),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (sda_in),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic                  byte_done_q, byte_done_d;
  logic                  scl_oe_q, scl_oe_d;
  logic                  sda_oe_q, sda_oe_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic [15:0]           stretch_cnt_q, stretch_cnt_d;

  // SCL must already have been high: releasing SCL and asserting ACK happen on
  // the same clk edge, and that must not look like a START.
  logic scl_high_stable, start_det, stop_det, handshake;
  assign scl_high_stable = scl_lvl & ~scl_rise;
  assign start_det       = sda_fall & scl_high_stable;
  assign stop_det        = sda_rise & scl_high_stable;
  assign handshake       = rx_valid_q & rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      byte_done_q   <= 1'b0;
      scl_oe_q      <= 1'b0;
      sda_oe_q      <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      stretch_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_done_q   <= byte_done_d;
      scl_oe_q      <= scl_oe_d;
      sda_oe_q      <= sda_oe_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
      stretch_cnt_q <= stretch_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    byte_done_d   = byte_done_q;
    scl_oe_d      = scl_oe_q;
    sda_oe_d      = sda_oe_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    busy_d        = busy_q;
    timeout_d     = 1'b0;
    stretch_cnt_d = stretch_cnt_q;

    if (start_det || stop_det) begin
      state_d       = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_d     = '0;
      byte_done_d   = 1'b0;
      scl_oe_d      = 1'b0;
      sda_oe_d      = 1'b0;
      rx_valid_d    = 1'b0;
      busy_d        = 1'b0;
      stretch_cnt_d = '0;
    end else begin
      if ((state_q == ST_ADDR || state_q == ST_DATA) && scl_rise) begin
        shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
      end

      unique case (state_q)
        ST_ADDR: begin
          if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (is_write_to(shift_q, TGT_ADDR)) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_DATA;
          end
        end
        ST_DATA: begin
          if (scl_fall && byte_done_q) begin
            byte_done_d   = 1'b0;
            rx_data_d     = shift_q;
            rx_valid_d    = 1'b1;
            scl_oe_d      = 1'b1;
            stretch_cnt_d = '0;
            state_d       = ST_STRETCH;
          end
        end
        ST_STRETCH: begin
          if (handshake) begin
            rx_valid_d = 1'b0;
            sda_oe_d   = 1'b1;
            scl_oe_d   = 1'b0;
            state_d    = ST_DATA_ACK;
          end else if (stretch_cnt_q == STRETCH_MAX) begin
            timeout_d  = 1'b1;
            rx_valid_d = 1'b0;
            scl_oe_d   = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            state_d    = ST_IGNORE;
          end else begin
            stretch_cnt_d = stretch_cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign scl_oe      = scl_oe_q;
  assign sda_oe      = sda_oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;

endmodule

// File: doc/i2c_target_stretch.md
I2C_TARGET_STRETCH -- requirements
Module: i2c_target_stretch

Interface
REQ-001 SHALL have parameter TGT_ADDR, default 7'h42, the 7-bit target address this block answers to.
REQ-002 SHALL have parameter STRETCH_MAX, default 16'd12000, the maximum number of clk cycles SCL is held low per byte.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 scl_in  input  1  raw bus SCL level (asynchronous).
REQ-006 sda_in  input  1  raw bus SDA level (asynchronous).
REQ-007 scl_oe  output  1  1 = pull SCL low (stretch); 0 = release.
REQ-008 sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
REQ-009 rx_data  output  8  received data byte, MSB first on the bus.
REQ-010 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-011 rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
REQ-012 busy  output  1  1 while addressed (from address ACK to STOP, repeated START or abort).
REQ-013 timeout_err  output  1  one-cycle pulse when a stretch exceeds STRETCH_MAX.

Function
REQ-014 scl_in and sda_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized levels (2-cycle input latency).
REQ-015 Edge detection SHALL compare each synchronized level with its 1-cycle-delayed copy.
REQ-016 START = SDA falling while SCL high; STOP = SDA rising while SCL high. Both SHALL be recognized in every state.
REQ-017 Data bits SHALL be sampled on the SCL rising edge and shifted in MSB first; sda_oe SHALL change only on an SCL falling edge, or in the cycle after the handshake (REQ-022).
REQ-018 States: IDLE, ADDR, ADDR_ACK, DATA, STRETCH, DATA_ACK, IGNORE.
REQ-019 IDLE->ADDR on START; any state->ADDR on repeated START; any state->IDLE on STOP. Both cases SHALL clear the bit counter and release sda_oe and scl_oe.
REQ-020 ADDR: after 8 bits, on the next SCL falling edge:
- addr == TGT_ADDR and R/W == 0: go to ADDR_ACK, set sda_oe=1, busy=1.
- otherwise: go to IGNORE, no drive (NACK); read requests are not supported.
REQ-021 ADDR_ACK/DATA_ACK: release sda_oe on the next SCL falling edge, then go to DATA.
REQ-022 DATA: after 8 bits, on the next SCL falling edge:
- load rx_data, set rx_valid=1 and scl_oe=1 in the same cycle, go to STRETCH.
- In STRETCH, on a cycle with rx_valid & rx_ready: next cycle rx_valid=0, sda_oe=1 (ACK), scl_oe=0, state DATA_ACK.
REQ-023 Stretch counter (16 bits) SHALL count clk cycles in STRETCH, starting at 0. When it reaches STRETCH_MAX with no handshake:
- pulse timeout_err, clear rx_valid, release scl_oe and sda_oe (NACK);
- go to IGNORE and clear busy.
REQ-024 A handshake in the same cycle the counter reaches STRETCH_MAX SHALL win: ACK, no timeout.
REQ-025 rx_ready while rx_valid=0 SHALL have no effect; rx_data SHALL stay stable while rx_valid=1.
REQ-026 The bit counter is 3 bits and SHALL wrap 7->0 at the end of each byte.
REQ-027 STOP or START while in STRETCH SHALL drop rx_valid (byte discarded) and release SCL.

Reset
REQ-028 On rst: state=IDLE, scl_oe=0, sda_oe=0, rx_valid=0, rx_data=8'h00, busy=0, timeout_err=0, counters=0, synchronizer flops=1 (bus idle).
REQ-029 Reset mid-transfer, including mid-stretch, SHALL release both lines in the cycle after rst is sampled.

Structure
REQ-030 Shared package i2c_pkg SHALL hold the state enum, I2C_ADDR_W=7 and I2C_BYTE_W=8.
REQ-031 Sub-module i2c_line_sync SHALL implement the synchronizer and rise/fall detection for one line; it SHALL be instantiated twice.

Verification
REQ-032 Write to 0x42 with byte 0xA5, rx_ready held 1 -> address ACKed, rx_data=0xA5, rx_valid for exactly 1 cycle, byte ACKed, busy low after STOP.
REQ-033 Write to 0x42 with byte 0x3C, rx_ready low for 500 cycles -> scl_oe high for about 501 cycles, then ACK; a master waiting on SCL sees no lost bit.
REQ-034 Address 0x43 write, and address 0x42 read -> no ACK on either, busy=0, rx_valid never asserted, state IGNORE until STOP.
REQ-035 STRETCH_MAX=100 with rx_ready held 0 -> timeout_err pulse at cycle 100 of the stretch, SCL released, NACK; rx_ready=1 exactly at cycle 100 -> ACK, no timeout.
REQ-036 Repeated START after byte 0x11, then address 0x42 write with byte 0x22 -> two bytes delivered in order 0x11, 0x22.
REQ-037 rst asserted mid-stretch -> all outputs at reset values next cycle; a following fresh transaction works normally.
